// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operation sequencer: FSM states, display
// letter codes and the helper that maps sequencer status to a letter.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [3:0] LET_A = 4'hA;  // waiting for operand A
  localparam logic [3:0] LET_B = 4'hB;  // waiting for operand B
  localparam logic [3:0] LET_C = 4'hC;  // waiting for opcode / executing
  localparam logic [3:0] LET_D = 4'hD;  // showing the latest result
  localparam logic [3:0] LET_E = 4'hE;  // wrong button pressed
  localparam logic [3:0] LET_F = 4'hF;  // browsing result history

  // Error beats browsing, browsing beats the plain state letter.
  function automatic logic [3:0] letter_code(input state_t s,
                                             input logic   err,
                                             input logic   browse);
    logic [3:0] code;
    code = LET_A;
    if (err) begin
      code = LET_E;
    end else if (browse) begin
      code = LET_F;
    end else begin
      case (s)
        S_A:         code = LET_A;
        S_B:         code = LET_B;
        S_OP,
        S_EXEC:      code = LET_C;
        S_SHOW:      code = LET_D;
        default:     code = LET_A;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// Rising-edge detector for one debounced push button. The previous sample
// is registered so a held button produces a single one-cycle rise.
module pb_edge_detect (
  input  logic slow_clk,
  input  logic reset_debounced,
  input  logic pb,
  output logic rise
);

  logic prev;

  // Remember last cycle's button level.
  always_ff @(posedge slow_clk or posedge reset_debounced) begin
    if (reset_debounced) begin
      prev <= 1'b0;
    end else begin
      prev <= pb;
    end
  end

  assign rise = pb & ~prev;

endmodule

// File: rtl/alu_op_sequencer.sv
// Push-button front end for an external combinational ALU. The user enters
// operand A, operand B and an opcode from the switches; the sequencer
// latches the ALU result, keeps a small circular history of results and
// lets the user browse it newest to oldest. letters/disp_val drive the
// display path.
//
// state  | meaning
// S_A    | waiting for operand A (reset state)
// S_B    | waiting for operand B
// S_OP   | waiting for the opcode
// S_EXEC | one cycle: ALU result is latched at its end
// S_SHOW | result on display; a/b/op start a new operation, hist browses
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OP_W       = 3,
  parameter int HIST_DEPTH = 4
) (
  input  logic             slow_clk,
  input  logic             reset_debounced,
  input  logic             pb_a,
  input  logic             pb_b,
  input  logic             pb_op,
  input  logic             pb_hist,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH:0]   alu_out,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [OP_W-1:0]  op_q,
  output logic [WIDTH-1:0] led,
  output logic [3:0]       letters,
  output logic [WIDTH:0]   disp_val,
  output logic             result_valid
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HIST_DEPTH);

  logic rise_a, rise_b, rise_op, rise_hist;
  logic acc_a, acc_b, acc_op, acc_hist;

  state_t           state;
  logic [WIDTH:0]   result_q;
  logic             err;
  logic             browse;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] newest_idx;
  logic [PTR_W-1:0] oldest_idx;
  logic             hist_we;

  logic [WIDTH:0]   hist_mem [HIST_DEPTH];

  pb_edge_detect u_edge_a (
    .slow_clk        (slow_clk),
    .reset_debounced (reset_debounced),
    .pb              (pb_a),
    .rise            (rise_a)
  );

  pb_edge_detect u_edge_b (
    .slow_clk        (slow_clk),
    .reset_debounced (reset_debounced),
    .pb              (pb_b),
    .rise            (rise_b)
  );

  pb_edge_detect u_edge_op (
    .slow_clk        (slow_clk),
    .reset_debounced (reset_debounced),
    .pb              (pb_op),
    .rise            (rise_op)
  );

  pb_edge_detect u_edge_hist (
    .slow_clk        (slow_clk),
    .reset_debounced (reset_debounced),
    .pb              (pb_hist),
    .rise            (rise_hist)
  );

  // At most one button is accepted per cycle: a > b > op > hist.
  always_comb begin
    acc_a    = rise_a;
    acc_b    = rise_b  & ~rise_a;
    acc_op   = rise_op & ~rise_a & ~rise_b;
    acc_hist = rise_hist & ~rise_a & ~rise_b & ~rise_op;
  end

  // With a full buffer count truncates to zero, making wr_ptr the oldest slot.
  always_comb begin
    newest_idx = wr_ptr - PTR_W'(1);
    oldest_idx = wr_ptr - count[PTR_W-1:0];
    hist_we    = (state == S_EXEC);
  end

  // Sequencer FSM with registered operands, result and browse pointer.
  always_ff @(posedge slow_clk or posedge reset_debounced) begin
    if (reset_debounced) begin
      state        <= S_A;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      led          <= '0;
      result_q     <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      browse       <= 1'b0;
      rd_idx       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_A: begin
          if (acc_a) begin
            a_q   <= sw;
            led   <= sw;
            err   <= 1'b0;
            state <= S_B;
          end else if (acc_b || acc_op) begin
            err <= 1'b1;
          end
        end
        S_B: begin
          if (acc_b) begin
            b_q   <= sw;
            led   <= sw;
            err   <= 1'b0;
            state <= S_OP;
          end else if (acc_a || acc_op) begin
            err <= 1'b1;
          end
        end
        S_OP: begin
          if (acc_op) begin
            op_q  <= sw[OP_W-1:0];
            led   <= WIDTH'(sw[OP_W-1:0]);
            err   <= 1'b0;
            state <= S_EXEC;
          end else if (acc_a || acc_b) begin
            err <= 1'b1;
          end
        end
        S_EXEC: begin
          result_q     <= alu_out;
          result_valid <= 1'b1;
          wr_ptr       <= wr_ptr + PTR_W'(1);
          if (count != CNT_FULL) begin
            count <= count + CNT_W'(1);
          end
          state <= S_SHOW;
        end
        S_SHOW: begin
          if (acc_a) begin
            a_q    <= sw;
            led    <= sw;
            err    <= 1'b0;
            browse <= 1'b0;
            state  <= S_B;
          end else if (acc_b) begin
            b_q    <= sw;
            led    <= sw;
            err    <= 1'b0;
            browse <= 1'b0;
            state  <= S_EXEC;
          end else if (acc_op) begin
            op_q   <= sw[OP_W-1:0];
            led    <= WIDTH'(sw[OP_W-1:0]);
            err    <= 1'b0;
            browse <= 1'b0;
            state  <= S_EXEC;
          end else if (acc_hist && (count != '0)) begin
            if (!browse) begin
              browse <= 1'b1;
              rd_idx <= newest_idx;
            end else if (rd_idx == oldest_idx) begin
              rd_idx <= newest_idx;
            end else begin
              rd_idx <= rd_idx - PTR_W'(1);
            end
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  // History storage; stale entries are masked by count, so no reset needed.
  always_ff @(posedge slow_clk) begin
    if (hist_we) begin
      hist_mem[wr_ptr] <= alu_out;
    end
  end

  // Display path selects between the browsed entry and the live result.
  always_comb begin
    letters  = letter_code(state, err, browse);
    disp_val = browse ? hist_mem[rd_idx] : result_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. A small ALU model drives
// alu_out; expected results are queued when an operation is launched and
// checked when result_valid pulses.
module tb_alu_op_sequencer;

  localparam int WIDTH = 8;
  localparam int OP_W  = 3;

  logic             slow_clk = 1'b0;
  logic             reset_debounced = 1'b1;
  logic             pb_a = 1'b0, pb_b = 1'b0, pb_op = 1'b0, pb_hist = 1'b0;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH:0]   alu_out;
  logic [WIDTH-1:0] a_q, b_q, led;
  logic [OP_W-1:0]  op_q;
  logic [3:0]       letters;
  logic [WIDTH:0]   disp_val;
  logic             result_valid;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [WIDTH:0] sb [$];

  alu_op_sequencer #(.WIDTH(WIDTH), .OP_W(OP_W), .HIST_DEPTH(4)) dut (
    .slow_clk        (slow_clk),
    .reset_debounced (reset_debounced),
    .pb_a            (pb_a),
    .pb_b            (pb_b),
    .pb_op           (pb_op),
    .pb_hist         (pb_hist),
    .sw              (sw),
    .alu_out         (alu_out),
    .a_q             (a_q),
    .b_q             (b_q),
    .op_q            (op_q),
    .led             (led),
    .letters         (letters),
    .disp_val        (disp_val),
    .result_valid    (result_valid)
  );

  always #5 slow_clk = ~slow_clk;

  // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A.
  always_comb begin
    alu_out = {1'b0, a_q};
    case (op_q)
      3'd0: alu_out = {1'b0, a_q} + {1'b0, b_q};
      3'd1: alu_out = {1'b0, a_q} - {1'b0, b_q};
      3'd2: alu_out = {1'b0, a_q & b_q};
      3'd3: alu_out = {1'b0, a_q | b_q};
      3'd4: alu_out = {1'b0, a_q ^ b_q};
      default: alu_out = {1'b0, a_q};
    endcase
  end

  // Scoreboard consumer: each result_valid pulse pops one expected result.
  always @(negedge slow_clk) begin
    if (result_valid) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got pulse with disp_val=%h, none expected", disp_val);
      end else begin
        logic [WIDTH:0] exp_r;
        exp_r = sb.pop_front();
        if (disp_val !== exp_r) begin
          errors++;
          $display("FAIL result_value: got %h expected %h", disp_val, exp_r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic a, input logic b, input logic o, input logic h,
                       input logic [WIDTH-1:0] v);
    sw = v; pb_a = a; pb_b = b; pb_op = o; pb_hist = h;
    @(negedge slow_clk);
    pb_a = 1'b0; pb_b = 1'b0; pb_op = 1'b0; pb_hist = 1'b0;
    @(negedge slow_clk);
  endtask

  task automatic do_reset();
    @(negedge slow_clk);
    reset_debounced = 1'b1;
    repeat (2) @(negedge slow_clk);
    reset_debounced = 1'b0;
    @(negedge slow_clk);
  endtask

  task automatic test_reset();
    @(negedge slow_clk);
    reset_debounced = 1'b1;
    #1;
    checks++; if (a_q !== 8'h00) begin errors++; $display("FAIL reset_a_q: got %h expected 00", a_q); end
    checks++; if (b_q !== 8'h00) begin errors++; $display("FAIL reset_b_q: got %h expected 00", b_q); end
    checks++; if (op_q !== 3'd0) begin errors++; $display("FAIL reset_op_q: got %h expected 0", op_q); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
    checks++; if (letters !== 4'hA) begin errors++; $display("FAIL reset_letters: got %h expected a", letters); end
    checks++; if (disp_val !== 9'h000) begin errors++; $display("FAIL reset_disp_val: got %h expected 000", disp_val); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
    @(negedge slow_clk);
    reset_debounced = 1'b0;
    @(negedge slow_clk);
    checks++; if (letters !== 4'hA) begin errors++; $display("FAIL reset_release_letters: got %h expected a", letters); end
  endtask

  task automatic test_basic_op();
    int p0;
    do_reset();
    p0 = pulses;
    pulse(1, 0, 0, 0, 8'h0F);
    checks++; if (a_q !== 8'h0F) begin errors++; $display("FAIL basic_a_q: got %h expected 0f", a_q); end
    checks++; if (led !== 8'h0F) begin errors++; $display("FAIL basic_led_a: got %h expected 0f", led); end
    checks++; if (letters !== 4'hB) begin errors++; $display("FAIL basic_letters_b: got %h expected b", letters); end
    pulse(0, 1, 0, 0, 8'h01);
    checks++; if (b_q !== 8'h01) begin errors++; $display("FAIL basic_b_q: got %h expected 01", b_q); end
    checks++; if (letters !== 4'hC) begin errors++; $display("FAIL basic_letters_c: got %h expected c", letters); end
    sb.push_back(9'h010);
    pulse(0, 0, 1, 0, 8'h00);
    repeat (3) @(negedge slow_clk);
    checks++; if (disp_val !== 9'h010) begin errors++; $display("FAIL basic_result: got %h expected 010", disp_val); end
    checks++; if (letters !== 4'hD) begin errors++; $display("FAIL basic_letters_d: got %h expected d", letters); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL basic_led_op: got %h expected 00", led); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL basic_pulse_count: got %0d expected 1", pulses - p0); end
  endtask

  task automatic test_hold();
    do_reset();
    sw = 8'h33; pb_a = 1'b1;
    @(negedge slow_clk);
    sw = 8'h44;
    repeat (9) @(negedge slow_clk);
    pb_a = 1'b0;
    @(negedge slow_clk);
    checks++; if (a_q !== 8'h33) begin errors++; $display("FAIL hold_a_q: got %h expected 33", a_q); end
    checks++; if (letters !== 4'hB) begin errors++; $display("FAIL hold_state: got letters %h expected b", letters); end
  endtask

  task automatic test_wrong_button();
    do_reset();
    pulse(0, 0, 0, 1, 8'h00);
    checks++; if (letters !== 4'hA) begin errors++; $display("FAIL hist_in_a_no_err: got %h expected a", letters); end
    pulse(0, 0, 1, 0, 8'h05);
    checks++; if (letters !== 4'hE) begin errors++; $display("FAIL wrong_err: got %h expected e", letters); end
    checks++; if (op_q !== 3'd0) begin errors++; $display("FAIL wrong_op_q: got %h expected 0", op_q); end
    pulse(1, 0, 0, 0, 8'h22);
    checks++; if (a_q !== 8'h22) begin errors++; $display("FAIL wrong_then_a_q: got %h expected 22", a_q); end
    checks++; if (letters !== 4'hB) begin errors++; $display("FAIL wrong_err_clear: got %h expected b", letters); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(1, 1, 0, 0, 8'h55);
    checks++; if (a_q !== 8'h55) begin errors++; $display("FAIL simul_a_q: got %h expected 55", a_q); end
    checks++; if (b_q !== 8'h00) begin errors++; $display("FAIL simul_b_q: got %h expected 00", b_q); end
    checks++; if (letters !== 4'hB) begin errors++; $display("FAIL simul_state: got letters %h expected b", letters); end
  endtask

  task automatic test_history();
    logic [WIDTH:0] exp_seq [5];
    exp_seq[0] = 9'd5; exp_seq[1] = 9'd4; exp_seq[2] = 9'd3;
    exp_seq[3] = 9'd2; exp_seq[4] = 9'd5;
    do_reset();
    pulse(1, 0, 0, 0, 8'd0);
    pulse(0, 1, 0, 0, 8'd1);
    sb.push_back(9'd1);
    pulse(0, 0, 1, 0, 8'd0);
    @(negedge slow_clk);
    for (int k = 2; k <= 5; k++) begin
      sb.push_back(9'(k));
      pulse(0, 1, 0, 0, 8'(k));
      @(negedge slow_clk);
    end
    for (int i = 0; i < 5; i++) begin
      pulse(0, 0, 0, 1, 8'h00);
      checks++;
      if (disp_val !== exp_seq[i]) begin
        errors++;
        $display("FAIL hist_browse_%0d: got %h expected %h", i, disp_val, exp_seq[i]);
      end
      checks++;
      if (letters !== 4'hF) begin
        errors++;
        $display("FAIL hist_letters_%0d: got %h expected f", i, letters);
      end
    end
    pulse(1, 0, 0, 0, 8'h07);
    checks++; if (letters !== 4'hB) begin errors++; $display("FAIL hist_exit: got letters %h expected b", letters); end
    checks++; if (disp_val !== 9'd5) begin errors++; $display("FAIL hist_exit_disp: got %h expected 005", disp_val); end
    pulse(0, 0, 0, 1, 8'h00);
    checks++; if (letters !== 4'hB) begin errors++; $display("FAIL hist_in_b_ignored: got %h expected b", letters); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(1, 0, 0, 0, 8'h30);
    pulse(0, 1, 0, 0, 8'h10);
    sb.push_back(9'h020);
    pulse(0, 0, 1, 0, 8'h01);
    @(negedge slow_clk);
    sb.push_back(9'h010);
    pulse(0, 0, 1, 0, 8'h02);
    @(negedge slow_clk);
    checks++; if (op_q !== 3'd2) begin errors++; $display("FAIL b2b_op_q: got %h expected 2", op_q); end
    sb.push_back(9'h030);
    pulse(0, 1, 0, 0, 8'hF0);
    @(negedge slow_clk);
    sb.push_back(9'h1E0);
    pulse(1, 0, 0, 0, 8'h10);
    pulse(0, 1, 0, 0, 8'h30);
    pulse(0, 0, 1, 0, 8'h09);
    @(negedge slow_clk);
    checks++; if (op_q !== 3'd1) begin errors++; $display("FAIL b2b_op_trunc: got %h expected 1", op_q); end
    checks++; if (led !== 8'h01) begin errors++; $display("FAIL b2b_led_zext: got %h expected 01", led); end
    checks++; if (letters !== 4'hD) begin errors++; $display("FAIL b2b_letters: got %h expected d", letters); end
  endtask

  task automatic test_reset_in_exec();
    int p0;
    do_reset();
    pulse(1, 0, 0, 0, 8'h0F);
    pulse(0, 1, 0, 0, 8'h01);
    sw = 8'h00; pb_op = 1'b1;
    @(negedge slow_clk);
    pb_op = 1'b0;
    checks++; if (letters !== 4'hC) begin errors++; $display("FAIL exec_reached: got letters %h expected c", letters); end
    p0 = pulses;
    reset_debounced = 1'b1;
    #1;
    checks++; if (a_q !== 8'h00) begin errors++; $display("FAIL exec_rst_a_q: got %h expected 00", a_q); end
    checks++; if (b_q !== 8'h00) begin errors++; $display("FAIL exec_rst_b_q: got %h expected 00", b_q); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL exec_rst_led: got %h expected 00", led); end
    checks++; if (letters !== 4'hA) begin errors++; $display("FAIL exec_rst_letters: got %h expected a", letters); end
    repeat (3) @(negedge slow_clk);
    reset_debounced = 1'b0;
    repeat (3) @(negedge slow_clk);
    checks++; if (pulses !== p0) begin errors++; $display("FAIL exec_rst_no_valid: got %0d pulses expected 0", pulses - p0); end
    checks++; if (dut.count !== '0) begin errors++; $display("FAIL exec_rst_count: got %0d expected 0", dut.count); end
    checks++; if (disp_val !== 9'h000) begin errors++; $display("FAIL exec_rst_disp: got %h expected 000", disp_val); end
    checks++; if (letters !== 4'hA) begin errors++; $display("FAIL exec_rst_state: got letters %h expected a", letters); end
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_hold();
    test_wrong_button();
    test_simultaneous();
    test_history();
    test_back_to_back();
    test_reset_in_exec();
    repeat (2) @(negedge slow_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding results expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter OP_W, default 3, opcode width in bits.
REQ-003 Parameter HIST_DEPTH, default 4, result-history entries; power of two, at least 2.
REQ-004 slow_clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 reset_debounced  in  1  reset; asynchronous, active-high.
REQ-006 pb_a, pb_b, pb_op, pb_hist  in  1 each  debounced push buttons, level.
REQ-007 sw  in  WIDTH  debounced switch value.
REQ-008 alu_out  in  WIDTH+1  combinational ALU result (carry in MSB) for a_q, b_q and op_q.
REQ-009 a_q, b_q  out  WIDTH each  captured operands.
REQ-010 op_q  out  OP_W  captured opcode.
REQ-011 led  out  WIDTH  last captured value; the opcode is zero-extended.
REQ-012 letters  out  4  display code.
REQ-013 disp_val  out  WIDTH+1  result or history entry for the BCD path.
REQ-014 result_valid  out  1  one-cycle pulse per executed operation.

Function
REQ-015 Each pb input SHALL be rising-edge detected against a registered previous sample: rise = pb & ~prev. A held button SHALL cause exactly one action.
REQ-016 Simultaneous rises SHALL be prioritised a > b > op > hist; at most one SHALL be accepted per cycle, and the others SHALL be discarded.
REQ-017 FSM states: S_A, S_B, S_OP, S_EXEC, S_SHOW. S_A SHALL be the reset state.
REQ-018 S_A: a rise on a SHALL capture sw into a_q and led, then go to S_B.
REQ-019 S_B: a rise on b SHALL capture sw into b_q and led, then go to S_OP.
REQ-020 S_OP: a rise on op SHALL capture sw[OP_W-1:0] into op_q, set led = zero-extended opcode, and go to S_EXEC.
REQ-021 S_EXEC SHALL last exactly one cycle.
REQ-022 At the end of S_EXEC the FSM SHALL latch alu_out into result_q, write it to the history, and pulse result_valid during the first S_SHOW cycle.
REQ-023 S_SHOW: a rise on a SHALL capture A and go to S_B.
REQ-024 S_SHOW: a rise on b SHALL capture B and go to S_EXEC (the opcode is reused).
REQ-025 S_SHOW: a rise on op SHALL capture the opcode and go to S_EXEC.
REQ-026 In S_A, S_B or S_OP, an accepted rise that is not the expected one SHALL be ignored, except that it SHALL set the sticky err flag.
REQ-027 err SHALL clear on the next valid capture.
REQ-028 letters SHALL follow this priority: 0xE if err; else 0xF if browsing; else S_A → 0xA, S_B → 0xB, S_OP/S_EXEC → 0xC, S_SHOW → 0xD.
REQ-029 History SHALL be a circular buffer of HIST_DEPTH entries. wr_ptr SHALL wrap modulo HIST_DEPTH. count SHALL saturate at HIST_DEPTH, so the oldest entry is overwritten.
REQ-030 In S_SHOW with count > 0, a rise on hist SHALL enter or advance browsing, with rd_idx stepping newest → oldest.
REQ-031 The step after the oldest valid entry SHALL wrap back to the newest.
REQ-032 Any other accepted rise SHALL exit browsing.
REQ-033 A rise on hist in any other state, or when count = 0, SHALL be ignored and SHALL NOT set err.
REQ-034 disp_val SHALL equal the history entry at rd_idx while browsing, and result_q otherwise.
REQ-035 Capture SHALL occur on the same clock edge at which the rise is sampled; outputs SHALL change after that edge.

Reset
REQ-036 Asserting reset SHALL immediately clear a_q, b_q, op_q, led, result_q, disp_val, result_valid, err, browse, rd_idx, wr_ptr, count, and all prev samples.
REQ-037 Asserting reset SHALL set the state to S_A and letters to 0xA.
REQ-038 Reset during S_EXEC SHALL discard the pending result: no history write and no result_valid pulse.
REQ-039 History contents need not be cleared, because count = 0 masks them.

Structure
REQ-040 Package alu_seq_pkg SHALL hold the state encoding and the letter codes (0xA–0xF).
REQ-041 Sub-module pb_edge_detect SHALL contain one prev register and one rise output, instantiated four times.
REQ-042 The history SHALL be a register array inside alu_op_sequencer; no RAM macro.

Verification
REQ-043 The bench SHALL pulse pb_a with sw=0x0F, pb_b with sw=0x01, and pb_op with sw=0, with the model driving alu_out=0x010. Required: result_q=0x010, one result_valid pulse, letters=0xD, led=0x00.
REQ-044 The bench SHALL hold pb_a high for 10 cycles in S_A. Required: one capture only, state=S_B.
REQ-045 The bench SHALL pulse pb_op in S_A. Required: letters=0xE, state still S_A. A following pb_a with sw=0x22 SHALL give a_q=0x22 and letters=0xB.
REQ-046 The bench SHALL pulse pb_a and pb_b in the same cycle in S_A with sw=0x55. Required: a_q=0x55, b_q unchanged at 0, state=S_B.
REQ-047 The bench SHALL execute five operations with results 1..5 (HIST_DEPTH=4), then pulse pb_hist five times. Required: disp_val sequence 5, 4, 3, 2, 5, and letters=0xF.
REQ-048 The bench SHALL assert reset during S_EXEC. Required: no result_valid, count=0, state=S_A, all outputs zero, letters=0xA.
